// File: rtl/maxpool2x2.sv
// maxpool2x2: 2x2 stride-2 signed max pooling of a CHANNELS x IMG_SIZE x IMG_SIZE buffer.
// Ports: clk / reset_n (async active-low) clock and reset; start launches one full pass;
//   conv_r_addr/conv_r_en/conv_r_q read the input buffer (data valid one cycle after enable);
//   pool_w_addr/pool_w_en/pool_w_we/pool_w_d write one pooled word per window;
//   busy is high for the whole pass and done pulses once at its end.
module maxpool2x2 #(
    parameter  int DATA_WIDTH = 16,
    parameter  int CHANNELS   = 8,
    parameter  int IMG_SIZE   = 28,
    localparam int P          = IMG_SIZE / 2,
    localparam int AWI        = $clog2(CHANNELS * IMG_SIZE * IMG_SIZE),
    localparam int AWO        = ($clog2(CHANNELS * P * P) > 1) ? $clog2(CHANNELS * P * P) : 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    output logic [AWI-1:0]               conv_r_addr,
    output logic                         conv_r_en,
    input  logic signed [DATA_WIDTH-1:0] conv_r_q,
    output logic [AWO-1:0]               pool_w_addr,
    output logic                         pool_w_en,
    output logic                         pool_w_we,
    output logic signed [DATA_WIDTH-1:0] pool_w_d,
    output logic                         busy,
    output logic                         done
);
    localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    localparam int PW = P > 1 ? $clog2(P) : 1;

    typedef enum logic [3:0] {
        IDLE, ISSUE0, CAPT0, ISSUE1, CAPT1, ISSUE2, CAPT2, ISSUE3, CAPT3, WRITE, FINISH
    } state_t;

    state_t                       state_q, state_d;
    logic [CW-1:0]                ch_q, ch_d;
    logic [PW-1:0]                pr_q, pr_d, pc_q, pc_d;
    logic signed [DATA_WIDTH-1:0] max_q, max_d;
    logic                         pc_end, pr_end, ch_end, issue, wr;
    logic [1:0]                   k;
    logic [31:0]                  row, col;

    assign pc_end = pc_q == PW'(P - 1);
    assign pr_end = pr_q == PW'(P - 1);
    assign ch_end = ch_q == CW'(CHANNELS - 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ch_q    <= '0;
            pr_q    <= '0;
            pc_q    <= '0;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            pr_q    <= pr_d;
            pc_q    <= pc_d;
            max_q   <= max_d;
        end
    end

    // ISSUE/CAPT states are laid out consecutively, so they simply step to the next encoding.
    // Counters only move in WRITE and wrap back to zero after the last window.
    always_comb begin
        case (state_q)
            IDLE:    state_d = start ? ISSUE0 : IDLE;
            WRITE:   state_d = (pc_end && pr_end && ch_end) ? FINISH : ISSUE0;
            FINISH:  state_d = IDLE;
            default: state_d = state_t'(state_q + 4'd1);
        endcase
        // First element loads unconditionally so all-negative windows survive.
        max_d = (state_q == CAPT0) ? conv_r_q :
                (state_q inside {CAPT1, CAPT2, CAPT3} && conv_r_q > max_q) ? conv_r_q : max_q;
        pc_d  = wr ? (pc_end ? '0 : pc_q + 1'b1) : pc_q;
        pr_d  = (wr && pc_end) ? (pr_end ? '0 : pr_q + 1'b1) : pr_q;
        ch_d  = (wr && pc_end && pr_end) ? (ch_end ? '0 : ch_q + 1'b1) : ch_q;
    end

    always_comb begin
        issue       = state_q inside {ISSUE0, ISSUE1, ISSUE2, ISSUE3};
        wr          = state_q == WRITE;
        k           = {state_q inside {ISSUE2, ISSUE3}, state_q inside {ISSUE1, ISSUE3}};
        row         = 32'(pr_q) * 2 + 32'(k[1]);
        col         = 32'(pc_q) * 2 + 32'(k[0]);
        conv_r_en   = issue;
        conv_r_addr = issue ? AWI'((32'(ch_q) * IMG_SIZE + row) * IMG_SIZE + col) : '0;
        pool_w_en   = wr;
        pool_w_we   = wr;
        pool_w_addr = wr ? AWO'((32'(ch_q) * P + 32'(pr_q)) * P + 32'(pc_q)) : '0;
        pool_w_d    = wr ? max_q : '0;
        busy        = state_q != IDLE;
        done        = state_q == FINISH;
    end
endmodule

// File: tb/tb_maxpool2x2.sv
// tb_maxpool2x2: checks maxpool2x2 (default and small odd-size instances) against a window-max model.
module tb_maxpool2x2;
    localparam int DW = 16;
    localparam int CA = 8, IA = 28, PA = 14, NA = CA * PA * PA;
    localparam int AWIA = $clog2(CA * IA * IA), AWOA = $clog2(NA);
    localparam int CB = 2, IB = 5, PB = 2, NB = CB * PB * PB;
    localparam int AWIB = $clog2(CB * IB * IB), AWOB = $clog2(NB);

    logic clk = 1'b0;
    logic reset_n, start_a, start_b;

    logic [AWIA-1:0]        a_raddr;
    logic                   a_ren, a_wen, a_we, a_busy, a_done;
    logic signed [DW-1:0]   a_q, a_wd;
    logic [AWOA-1:0]        a_waddr;
    logic [AWIB-1:0]        b_raddr;
    logic                   b_ren, b_wen, b_we, b_busy, b_done;
    logic signed [DW-1:0]   b_q, b_wd;
    logic [AWOB-1:0]        b_waddr;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    logic signed [DW-1:0] mem_a [CA*IA*IA];
    logic signed [DW-1:0] mem_b [CB*IB*IB];
    int exp_a [NA];
    int exp_b [NB];
    int got_b [NB];
    int lit_ramp [NB] = '{6, 8, 16, 18, -1, -3, -11, -13};
    int a_s = 0, b_s = 0, a_wr = 0, b_wr = 0, a_done_rel = -1, b_done_rel = -1;
    bit a_act = 0, b_act = 0;

    maxpool2x2 #(.DATA_WIDTH(DW), .CHANNELS(CA), .IMG_SIZE(IA)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a),
        .conv_r_addr(a_raddr), .conv_r_en(a_ren), .conv_r_q(a_q),
        .pool_w_addr(a_waddr), .pool_w_en(a_wen), .pool_w_we(a_we), .pool_w_d(a_wd),
        .busy(a_busy), .done(a_done)
    );

    maxpool2x2 #(.DATA_WIDTH(DW), .CHANNELS(CB), .IMG_SIZE(IB)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b),
        .conv_r_addr(b_raddr), .conv_r_en(b_ren), .conv_r_q(b_q),
        .pool_w_addr(b_waddr), .pool_w_en(b_wen), .pool_w_we(b_we), .pool_w_d(b_wd),
        .busy(b_busy), .done(b_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read buffers: data appears the cycle after the enable.
    always @(posedge clk) if (a_ren) a_q <= mem_a[a_raddr];
    always @(posedge clk) if (b_ren) b_q <= mem_b[b_raddr];

    task automatic chk(input string nm, input int act, input int want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, want);
        end
    endtask

    // Address of the element read in cycle rel (1-based from the start edge): 9 cycles per window,
    // reads on its 1st/3rd/5th/7th cycle in order (0,0),(0,1),(1,0),(1,1).
    function automatic int rd_addr(input int ii, input int pi, input int rel);
        int n  = (rel - 1) / 9;
        int kk = ((rel - 1) % 9) / 2;
        int ch = n / (pi * pi);
        int pr = (n / pi) % pi;
        int pc = n % pi;
        return (ch * ii + 2 * pr + kk / 2) * ii + 2 * pc + kk % 2;
    endfunction

    task automatic check_cycle(input string nm, input int ni, input int ii, input int pi, input int rel,
                               input logic bsy, input logic dn, input logic ren, input int raddr,
                               input logic wen, input logic we, input int waddr, input int wd, input int expd);
        bit run = rel >= 1 && rel <= 9 * ni + 1;
        bit wr  = run && rel <= 9 * ni && rel % 9 == 0;
        bit rd  = run && rel <= 9 * ni && (rel - 1) % 9 < 7 && ((rel - 1) % 9) % 2 == 0;
        chk({nm, "_busy"}, int'(bsy), int'(run));
        chk({nm, "_done"}, int'(dn), int'(rel == 9 * ni + 1));
        chk({nm, "_r_en"}, int'(ren), int'(rd));
        chk({nm, "_w_en"}, int'(wen), int'(wr));
        chk({nm, "_w_we"}, int'(we), int'(wr));
        if (rd) chk({nm, "_r_addr"}, raddr, rd_addr(ii, pi, rel));
        if (wr) chk({nm, "_w_addr"}, waddr, rel / 9 - 1);
        if (wr) chk({nm, "_w_data"}, wd, expd);
    endtask

    task automatic zero_chk(input string nm, input int raddr, input logic ren, input int waddr,
                            input logic wen, input logic we, input int wd, input logic bsy, input logic dn);
        chk({nm, "_rst_r_addr"}, raddr, 0);
        chk({nm, "_rst_r_en"}, int'(ren), 0);
        chk({nm, "_rst_w_addr"}, waddr, 0);
        chk({nm, "_rst_w_en"}, int'(wen), 0);
        chk({nm, "_rst_w_we"}, int'(we), 0);
        chk({nm, "_rst_w_d"}, wd, 0);
        chk({nm, "_rst_busy"}, int'(bsy), 0);
        chk({nm, "_rst_done"}, int'(dn), 0);
    endtask

    always @(negedge clk) begin : cmp_a
        int rel, idx;
        rel = a_act ? cyc - a_s + 1 : 0;
        idx = (rel >= 9 && rel <= 9 * NA) ? rel / 9 - 1 : 0;
        check_cycle("a", NA, IA, PA, rel, a_busy, a_done, a_ren, int'(a_raddr),
                    a_wen, a_we, int'(a_waddr), int'(a_wd), exp_a[idx]);
        if (a_wen) a_wr++;
        if (a_done) a_done_rel = rel;
    end

    always @(negedge clk) begin : cmp_b
        int rel, idx;
        rel = b_act ? cyc - b_s + 1 : 0;
        idx = (rel >= 9 && rel <= 9 * NB) ? rel / 9 - 1 : 0;
        check_cycle("b", NB, IB, PB, rel, b_busy, b_done, b_ren, int'(b_raddr),
                    b_wen, b_we, int'(b_waddr), int'(b_wd), exp_b[idx]);
        if (b_ren) chk("b_read_in_even_area",
                       int'((int'(b_raddr) % (IB * IB)) / IB < 2 * PB && int'(b_raddr) % IB < 2 * PB), 1);
        if (b_wen) begin
            b_wr++;
            got_b[b_waddr] = int'(b_wd);
        end
        if (b_done) b_done_rel = rel;
    end

    task automatic model_a();
        for (int ch = 0; ch < CA; ch++)
            for (int pr = 0; pr < PA; pr++)
                for (int pc = 0; pc < PA; pc++) begin
                    int base = (ch * IA + 2 * pr) * IA + 2 * pc;
                    int m = mem_a[base];
                    if (mem_a[base + 1] > m) m = mem_a[base + 1];
                    if (mem_a[base + IA] > m) m = mem_a[base + IA];
                    if (mem_a[base + IA + 1] > m) m = mem_a[base + IA + 1];
                    exp_a[(ch * PA + pr) * PA + pc] = m;
                end
    endtask

    task automatic model_b();
        for (int ch = 0; ch < CB; ch++)
            for (int pr = 0; pr < PB; pr++)
                for (int pc = 0; pc < PB; pc++) begin
                    int base = (ch * IB + 2 * pr) * IB + 2 * pc;
                    int m = mem_b[base];
                    if (mem_b[base + 1] > m) m = mem_b[base + 1];
                    if (mem_b[base + IB] > m) m = mem_b[base + IB];
                    if (mem_b[base + IB + 1] > m) m = mem_b[base + IB + 1];
                    exp_b[(ch * PB + pr) * PB + pc] = m;
                end
    endtask

    task automatic fill_a();
        for (int i = 0; i < CA * IA * IA; i++) mem_a[i] = DW'($urandom);
        model_a();
    endtask

    task automatic run_b();
        b_wr = 0;
        b_done_rel = -1;
        for (int n = 0; n < NB; n++) got_b[n] = -99999;
        @(posedge clk); #1 start_b = 1; b_s = cyc + 1; b_act = 1;
        @(posedge clk); #1 start_b = 0;
        repeat (9 * NB + 8) @(posedge clk);
        #1;
        chk("b_done_cycle", b_done_rel, 73);
        chk("b_write_count", b_wr, 8);
    endtask

    task automatic run_a(input bit stray);
        a_wr = 0;
        a_done_rel = -1;
        @(posedge clk); #1 start_a = 1; a_s = cyc + 1; a_act = 1;
        @(posedge clk); #1 start_a = 0;
        if (stray) begin
            repeat (40) @(posedge clk);
            #1 start_a = 1;
            @(posedge clk); #1 start_a = 0;
            while (cyc < a_s + 9 * NA) begin @(posedge clk); #1; end
            start_a = 1;
            @(posedge clk); #1 start_a = 0;
        end
        while (cyc < a_s + 9 * NA + 20) begin @(posedge clk); #1; end
        chk("a_done_cycle", a_done_rel, 14113);
        chk("a_write_count", a_wr, 1568);
    endtask

    initial begin
        reset_n = 1;
        start_a = 0;
        start_b = 0;
        #2 reset_n = 0;
        #1;
        zero_chk("a", int'(a_raddr), a_ren, int'(a_waddr), a_wen, a_we, int'(a_wd), a_busy, a_done);
        zero_chk("b", int'(b_raddr), b_ren, int'(b_waddr), b_wen, b_we, int'(b_wd), b_busy, b_done);
        repeat (3) @(posedge clk);
        #1 reset_n = 1;
        repeat (5) @(posedge clk);

        // Ramp in channel 0, strictly negative mirror in channel 1.
        for (int ch = 0; ch < CB; ch++)
            for (int r = 0; r < IB; r++)
                for (int c = 0; c < IB; c++)
                    mem_b[(ch * IB + r) * IB + c] = DW'(ch == 0 ? r * IB + c : -(r * IB + c) - 1);
        model_b();
        for (int n = 0; n < NB; n++) chk("model_ramp", exp_b[n], lit_ramp[n]);
        run_b();
        for (int n = 0; n < NB; n++) chk("b_ramp_word", got_b[n], lit_ramp[n]);

        // Odd size: the unread last row/column holds huge values that must never win.
        for (int ch = 0; ch < CB; ch++)
            for (int r = 0; r < IB; r++)
                for (int c = 0; c < IB; c++)
                    mem_b[(ch * IB + r) * IB + c] = DW'((r == 4 || c == 4) ? 32767 : 1);
        model_b();
        run_b();
        for (int n = 0; n < NB; n++) chk("b_odd_word", got_b[n], 1);

        // Random negatives, with one window whose maximum is its second element.
        for (int i = 0; i < CB * IB * IB; i++) mem_b[i] = DW'(-1 - int'($urandom_range(0, 30000)));
        mem_b[0] = -5; mem_b[1] = -3; mem_b[5] = -9; mem_b[6] = -7;
        model_b();
        run_b();
        chk("b_neg_window", got_b[0], -3);

        fill_a();
        run_a(1);

        // Reset in CAPT2 of the second window: no more writes, then a clean rerun.
        fill_a();
        a_wr = 0;
        @(posedge clk); #1 start_a = 1; a_s = cyc + 1; a_act = 1;
        @(posedge clk); #1 start_a = 0;
        while (cyc < a_s + 14) begin @(posedge clk); #1; end
        #1 reset_n = 0;
        a_act = 0;
        #1;
        zero_chk("a_mid", int'(a_raddr), a_ren, int'(a_waddr), a_wen, a_we, int'(a_wd), a_busy, a_done);
        chk("a_writes_before_reset", a_wr, 1);
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        repeat (40) @(posedge clk);
        #1;
        chk("a_writes_after_reset", a_wr, 1);
        fill_a();
        run_a(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
